// File: rtl/segmented_image_loader.sv
// Loads length-prefixed image segments into memory as little-endian packed words and releases
// the cores once the whole image is resident. Define LOADER_CHECKSUM_EN for per-segment XOR checksums.
module segmented_image_loader #(
   parameter int ADDR_WIDTH   = 21,
   parameter int DATA_WIDTH   = 64,
   parameter int NUM_SEGMENTS = 2,
   parameter logic [NUM_SEGMENTS*ADDR_WIDTH-1:0] SEG_BASES = {21'h10000, 21'h00000},
   parameter int NUM_CORES    = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    in_valid,
   input  logic [7:0]              in_data,
   output logic                    in_ready,
   output logic                    mem_wr_valid,
   input  logic                    mem_wr_ready,
   output logic [ADDR_WIDTH-1:0]   mem_wr_addr,
   output logic [DATA_WIDTH-1:0]   mem_wr_data,
   output logic [DATA_WIDTH/8-1:0] mem_wr_be,
   output logic                    busy,
   output logic                    done,
   output logic                    error,
   output logic [NUM_CORES-1:0]    core_run,
   output logic [31:0]             bytes_loaded
);
   localparam int BYTES = DATA_WIDTH / 8;
   localparam int BI_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam int SEG_W = $clog2(NUM_SEGMENTS + 1);
   localparam logic [ADDR_WIDTH:0] ADDR_STEP = (ADDR_WIDTH + 1)'(BYTES);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN, S_PAYLOAD, S_WRITE, S_CSUM, S_NEXT, S_DONE, S_ERROR
   } state_e;

`ifdef LOADER_CHECKSUM_EN
   localparam state_e AFTER_PAYLOAD = S_CSUM;
`else
   localparam state_e AFTER_PAYLOAD = S_NEXT;
`endif

   state_e                  state_q, state_d;
   logic [31:0]             len_q, len_d;
   logic [1:0]              lcnt_q, lcnt_d;
   logic [BI_W-1:0]         bi_q, bi_d;
   logic [DATA_WIDTH-1:0]   buf_q, buf_d;
   logic [BYTES-1:0]        be_q, be_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic                    ovf_q, ovf_d;
   logic [SEG_W-1:0]        seg_q, seg_d;
   logic [31:0]             bytes_q, bytes_d;
   logic [7:0]              csum_q, csum_d;
   logic [ADDR_WIDTH-1:0]   seg_base;
   logic [31:0]             len_full;
   logic                    in_fire;

   assign in_fire  = in_valid && in_ready;
   assign len_full = {in_data, len_q[23:0]};

   // The leftmost slice of SEG_BASES is segment 0, so the literal reads in stream order.
   always_comb begin
      seg_base = '0;
      for (int k = 0; k < NUM_SEGMENTS; k++)
         if (seg_q == SEG_W'(k))
            seg_base = SEG_BASES[(NUM_SEGMENTS-1-k)*ADDR_WIDTH +: ADDR_WIDTH];
   end

   // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE, S_DONE, S_ERROR: if (start) state_d = S_LEN;
         S_LEN:     if (in_fire && lcnt_q == 2'd3)
                       state_d = (len_full == 32'd0) ? AFTER_PAYLOAD : S_PAYLOAD;
         S_PAYLOAD: if (in_fire && (bi_q == BI_W'(BYTES-1) || len_q == 32'd1))
                       state_d = ovf_q ? S_ERROR : S_WRITE;
         S_WRITE:   if (mem_wr_ready) state_d = (len_q != 32'd0) ? S_PAYLOAD : AFTER_PAYLOAD;
         S_CSUM:    if (in_fire) state_d = (in_data == csum_q) ? S_NEXT : S_ERROR;
         S_NEXT:    state_d = (seg_q == SEG_W'(NUM_SEGMENTS-1)) ? S_DONE : S_LEN;
         default:   state_d = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready     = 1'b0;
      mem_wr_valid = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      error        = 1'b0;
      core_run     = '0;
      unique case (state_q)
         S_LEN, S_PAYLOAD, S_CSUM: begin in_ready = 1'b1; busy = 1'b1; end
         S_WRITE: begin mem_wr_valid = 1'b1; busy = 1'b1; end
         S_NEXT:  busy = 1'b1;
         S_DONE:  begin done = 1'b1; core_run = '1; end
         S_ERROR: error = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      len_d   = len_q;
      lcnt_d  = lcnt_q;
      bi_d    = bi_q;
      buf_d   = buf_q;
      be_d    = be_q;
      addr_d  = addr_q;
      ovf_d   = ovf_q;
      seg_d   = seg_q;
      bytes_d = bytes_q;
      csum_d  = csum_q;
      unique case (state_q)
         S_IDLE, S_DONE, S_ERROR: if (start) begin
            len_d = '0; lcnt_d = '0; bi_d = '0; buf_d = '0; be_d = '0;
            ovf_d = 1'b0; seg_d = '0; bytes_d = '0; csum_d = '0;
         end
         S_LEN: if (in_fire) begin
            len_d[8*lcnt_q +: 8] = in_data;
            lcnt_d = lcnt_q + 2'd1;
            if (lcnt_q == 2'd3) begin
               addr_d = seg_base;
               ovf_d  = 1'b0;
            end
         end
         S_PAYLOAD: if (in_fire) begin
            buf_d[8*bi_q +: 8] = in_data;
            be_d[bi_q] = 1'b1;
            bi_d    = bi_q + BI_W'(1);
            len_d   = len_q - 32'd1;
            bytes_d = bytes_q + 32'd1;
            csum_d  = csum_q ^ in_data;
         end
         // A carry out of the address marks the next word as lying beyond the top of memory.
         S_WRITE: if (mem_wr_ready) begin
            {ovf_d, addr_d} = {1'b0, addr_q} + ADDR_STEP;
            bi_d  = '0;
            buf_d = '0;
            be_d  = '0;
         end
         S_NEXT: begin
            seg_d  = seg_q + SEG_W'(1);
            len_d  = '0;
            lcnt_d = '0;
            csum_d = '0;
         end
         default: ;
      endcase
   end

   // NOTE: the word buffer is a handful of flops, not a RAM, so it is cleared on reset like the rest.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         len_q   <= '0;
         lcnt_q  <= '0;
         bi_q    <= '0;
         buf_q   <= '0;
         be_q    <= '0;
         addr_q  <= '0;
         ovf_q   <= 1'b0;
         seg_q   <= '0;
         bytes_q <= '0;
         csum_q  <= '0;
      end else begin
         len_q   <= len_d;
         lcnt_q  <= lcnt_d;
         bi_q    <= bi_d;
         buf_q   <= buf_d;
         be_q    <= be_d;
         addr_q  <= addr_d;
         ovf_q   <= ovf_d;
         seg_q   <= seg_d;
         bytes_q <= bytes_d;
         csum_q  <= csum_d;
      end
   end

   assign mem_wr_addr  = addr_q;
   assign mem_wr_data  = buf_q;
   assign mem_wr_be    = be_q;
   assign bytes_loaded = bytes_q;

endmodule
